// File: rtl/obi_pkg.sv
`default_nettype none
// obi_pkg: shared state encoding, command payload type and address-window check
// for the OBI data-port initiator.
package obi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LERR = 2'd2,
    HANG = 2'd3
  } obi_mst_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_cmd_t;

  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] start,
                                      input logic [31:0] mask);
    return (addr[1:0] == 2'b00) && ((addr & ~mask) == start);
  endfunction

endpackage
`default_nettype wire

// File: rtl/obi_pending_fifo.sv
`default_nettype none
// obi_pending_fifo: 1-bit-wide FIFO of store/load flags for granted requests;
// a push and pop on an empty FIFO falls straight through.
module obi_pending_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         push_data,
  input  logic                         pop,
  output logic                         pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             empty;
  logic             bypass;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  // Push and pop together on an empty FIFO leave its contents untouched.
  assign bypass   = push && pop && empty;
  assign do_push  = push && !bypass;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? push_data : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/obi_data_master.sv
`default_nettype none
// obi_data_master: turns single load/store commands into req/gnt/rvalid bus
// transactions and returns in-order responses, local errors and hang/protocol flags.
module obi_data_master
  import obi_pkg::*;
#(
  parameter logic [31:0] MEM_START       = 32'h0000_0000,
  parameter logic [31:0] MEM_MASK        = 32'h0000_FFFF,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          TIMEOUT_CYCLES  = 64
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_be,
  input  logic [31:0] cmd_wdata,
  output logic        data_req,
  input  logic        data_gnt,
  input  logic        data_rvalid,
  output logic        data_we,
  output logic [3:0]  data_be,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  output logic        rsp_valid,
  output logic        rsp_we,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        timeout,
  output logic        proto_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  obi_mst_state_e state;
  obi_mst_state_e state_n;
  obi_cmd_t       cmd_q;
  logic           lerr_we;
  logic [CW-1:0]  outstanding;
  logic [TW-1:0]  tmo_cnt;
  logic           accept;
  logic           legal;
  logic           push;
  logic           pop;
  logic           pop_we;
  logic           proto_set;
  logic           tmo_inc;
  logic           tmo_hit;
  logic           lerr_fire;

  assign legal  = addr_legal(cmd_addr, MEM_START, MEM_MASK);
  assign accept = cmd_valid && cmd_ready;
  assign push   = (state == REQ) && data_gnt;
  // The responder may answer in the grant cycle, so a push makes a pop legal
  // even with nothing outstanding yet.
  assign pop       = data_rvalid && (state != HANG) && ((outstanding != '0) || push);
  assign proto_set = data_rvalid && (state != HANG) && (outstanding == '0) && !push;
  assign tmo_inc   = (state != HANG) && (outstanding != '0) && !data_rvalid;
  assign tmo_hit   = tmo_inc && (tmo_cnt == TMO_LAST);

  obi_pending_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_pending (
    .clk       (clk_sys),
    .rst       (rst_sys),
    .push      (push),
    .push_data (data_we),
    .pop       (pop),
    .pop_data  (pop_we),
    .count     (outstanding)
  );

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    data_req  = 1'b0;
    lerr_fire = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !rst_sys && (outstanding < MAX_CNT);
        if (cmd_valid && cmd_ready) state_n = legal ? REQ : LERR;
      end
      REQ: begin
        data_req = 1'b1;
        if (data_gnt) state_n = IDLE;
      end
      LERR: begin
        // Holding the error until the bus drains keeps responses in issue order.
        if ((outstanding == '0) && !data_rvalid) begin
          lerr_fire = 1'b1;
          state_n   = IDLE;
        end
      end
      default: ;
    endcase
    if (tmo_hit) state_n = HANG;
  end

  assign data_we    = cmd_q.we;
  assign data_addr  = cmd_q.addr;
  assign data_be    = cmd_q.be;
  assign data_wdata = cmd_q.wdata;

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      cmd_q     <= '0;
      lerr_we   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      proto_err <= 1'b0;
      timeout   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      if (accept && legal)  cmd_q   <= {cmd_we, cmd_addr, cmd_be, cmd_wdata};
      if (accept && !legal) lerr_we <= cmd_we;
      rsp_valid <= pop || lerr_fire;
      rsp_we    <= pop ? pop_we : (lerr_fire && lerr_we);
      rsp_rdata <= (pop && !pop_we) ? data_rdata : '0;
      rsp_err   <= lerr_fire;
      proto_err <= proto_err || proto_set;
      timeout   <= timeout || tmo_hit;
      if (!tmo_inc)                tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TMO_ONE;
    end
  end

endmodule
`default_nettype wire

// File: doc/obi_data_master.md
# obi_data_master

Bus initiator for the core-style data port (req/gnt/rvalid handshake). It converts single load/store commands from a testbench-side or RTL-side command port into protocol-correct transactions toward the RAM arbiter responder, and returns read data and status in order. It sits where the Ibex LSU would sit, so the memory model and arbiter can be exercised, and regressed, without the core.

## Interface
Parameters:
- MEM_START, 32'h00000000, base of the legal address window.
- MEM_MASK, 32'h0000FFFF, window mask; an address is legal iff (addr & ~MEM_MASK) == MEM_START.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests (1..4).
- TIMEOUT_CYCLES, 64, cycles without rvalid while requests are outstanding before hang.

Ports (one clock; reset is asynchronous and active-high):
- clk_sys  in  1  clock.
- rst_sys  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_we  in  1  1 = store, 0 = load.
- cmd_addr  in  32  byte address; must be word aligned.
- cmd_be  in  4  byte enables.
- cmd_wdata  in  32  store data.
- data_req  out  1  bus request.
- data_gnt  in  1  bus grant.
- data_rvalid  in  1  bus response valid.
- data_we, data_be, data_addr, data_wdata  out  1/4/32/32  request payload.
- data_rdata  in  32  response data.
- rsp_valid  out  1  one-cycle response pulse, no backpressure.
- rsp_we  out  1  response belongs to a store.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  local error (misaligned or out of window).
- timeout  out  1  sticky hang flag.
- proto_err  out  1  sticky flag: rvalid with nothing outstanding.

## Operation
- FSM states: IDLE, REQ, LERR, HANG.
- IDLE:
  - cmd_ready = 1 iff outstanding < MAX_OUTSTANDING.
  - On accept of a legal command (cmd_addr[1:0] == 0 and in window): register the payload onto the data_* outputs and go to REQ.
  - On accept of an illegal command: go to LERR; no bus activity.
- REQ:
  - data_req = 1; payload held stable until data_gnt.
  - On gnt: push cmd_we into the pending FIFO (depth MAX_OUTSTANDING), outstanding++, go to IDLE; data_req is low the next cycle.
- LERR:
  - Wait until outstanding == 0 and data_rvalid == 0, which preserves response order.
  - Then emit rsp_valid with rsp_err = 1, rsp_we = command we, rsp_rdata = 0; go to IDLE.
- Each data_rvalid pops the pending FIFO and outstanding--.
  - Registered response next cycle: rsp_we = popped flag; rsp_rdata = data_rdata for loads, 0 for stores; rsp_err = 0.
- Same-cycle gnt and rvalid: the responder issues rvalid in the grant cycle.
  - rvalid retires the oldest entry, which may be the entry being granted that cycle (push and pop net zero when outstanding was 0).
  - Outstanding count is unchanged.
- rvalid with outstanding == 0 and no gnt: set proto_err (sticky); no response, FIFO untouched.
- Timeout counter:
  - Clears on rvalid or when outstanding == 0; otherwise increments.
  - Reaching TIMEOUT_CYCLES: go to HANG, timeout = 1.
- HANG is terminal until reset: cmd_ready = 0, data_req = 0, rvalid ignored.
- Counter width is clog2(TIMEOUT_CYCLES+1); it saturates and does not wrap.

## Timing
- Reset (async assert, sync release): state IDLE, all outputs 0, FIFO empty, counters 0.
  - cmd_ready rises the first cycle after release.
- Accept to data_req: 1 cycle. Minimum spacing between requests: 2 cycles (IDLE→REQ→IDLE).
- data_rvalid to rsp_valid: 1 cycle; rsp_rdata is valid only while rsp_valid = 1.
- Local-error response: 1 cycle after LERR is entered with the bus drained.
- Reset mid-transaction: state, FIFO and counters clear; data_req drops immediately.
  - Late rvalid after reset flags proto_err.
- cmd_ready is combinational from state and outstanding only, never from cmd_* inputs.

## Structure
- Shared package obi_pkg:
  - state enum obi_mst_state_e {IDLE, REQ, LERR, HANG};
  - struct obi_cmd_t {we, addr, be, wdata};
  - function addr_legal().
- One sub-module: obi_pending_fifo, a parameterised 1-bit-wide FIFO with depth MAX_OUTSTANDING.
  - Supports simultaneous push/pop when empty (fall-through).

## Test plan
- Store 0xDEADBEEF to 0x100 with be = 4'hF, then load 0x100:
  - Store: rsp_we = 1, rsp_rdata = 0.
  - Load: rsp_rdata = 0xDEADBEEF; RAM word 0x40 = 0xDEADBEEF.
- Load 0x102 (misaligned) and 0x00010000 (out of window):
  - Each gives rsp_err = 1, rsp_rdata = 0.
  - data_req is never asserted.
- Back-to-back commands with a responder that delays rvalid by 3 cycles:
  - At most 2 outstanding; cmd_ready drops at 2.
  - Responses return in issue order with the correct rsp_we.
- Illegal command issued behind 2 outstanding loads:
  - Error response appears only after both load responses.
- Responder never asserts rvalid:
  - timeout = 1 exactly TIMEOUT_CYCLES = 64 cycles after the grant.
  - cmd_ready stays 0 until rst_sys, then all outputs return to 0.
- Inject rvalid while idle:
  - proto_err = 1, no rsp_valid, subsequent transactions complete normally.
